// File: rtl/huc6270_irq_ctl.sv
// HuC6270 VDC status/interrupt controller: register-select latch, CR/RCR/DCR, six event flags, INT.
// Latency: flags and INT update one CE cycle after the event; DO is combinational from current state.
// Backpressure: none; CPU accesses complete in one cycle, events are never stalled or dropped.
module huc6270_irq_ctl #(
    parameter int ROW_W    = 9,
    parameter int COL_W    = 9,
    parameter int VBL_ROW  = 239,
    parameter int EVT_COL  = 0,
    parameter int RCR_BASE = 64
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             CE,
    input  logic             CSn,
    input  logic             WRn,
    input  logic             RDn,
    input  logic             A2,
    input  logic [15:0]      DI,
    output logic [15:0]      DO,
    output logic             INT,
    input  logic             PCE,
    input  logic [ROW_W-1:0] ROW,
    input  logic [COL_W-1:0] COL,
    input  logic             SPR_COLL,
    input  logic             SPR_OVF,
    input  logic             SATB_DONE,
    input  logic             VDMA_DONE,
    input  logic             BUSY
);
    // Flag vector bit order matches the status word: CR, OR, RR, DS, DV, VD.
    logic [4:0]  rsel;
    logic [3:0]  cr_q;
    logic [9:0]  rcr_q;
    logic [1:0]  dcr_q;
    logic [5:0]  flags;
    logic [5:0]  snap;
    logic        rd_act;

    logic        wr_en;
    logic        stat_rd;
    logic        rd_start;
    logic        rd_end;
    logic        evt_col;
    logic        vbl_hit;
    logic        rcr_hit;
    logic [9:0]  row_cmp;
    logic [5:0]  en_mask;
    logic [5:0]  ev_vec;
    logic [5:0]  set_vec;
    logic [5:0]  clr_mask;
    logic [5:0]  flags_nxt;
    logic [15:0] status;

    // Upper data bits have no register to land in.
    logic        unused_di;
    assign unused_di = ^DI[15:10];

    assign wr_en    = !CSn && !WRn;
    assign stat_rd  = !CSn && !RDn && (!A2 || (rsel == 5'h00));
    assign rd_start = stat_rd && !rd_act;
    assign rd_end   = RDn && rd_act;

    assign evt_col  = (COL == COL_W'(EVT_COL));
    assign vbl_hit  = PCE && evt_col && (ROW == ROW_W'(VBL_ROW));
    // Raster compare wraps modulo 1024, so some RCR values are never reached.
    assign row_cmp  = 10'(ROW) + 10'(RCR_BASE);
    assign rcr_hit  = PCE && evt_col && (row_cmp == rcr_q);

    assign en_mask  = {cr_q[3], dcr_q[1], dcr_q[0], cr_q[2], cr_q[1], cr_q[0]};
    assign ev_vec   = {vbl_hit, VDMA_DONE, SATB_DONE, rcr_hit, SPR_OVF, SPR_COLL};
    assign set_vec  = ev_vec & en_mask;
    // Only flags captured at read start are cleared; a new set in the same cycle wins.
    assign clr_mask = rd_end ? snap : 6'b0;
    assign flags_nxt = (flags & ~clr_mask) | set_vec;

    assign status   = {9'b0, BUSY, flags};
    // INT depends only on registered flags and enables.
    assign INT      = |(flags & en_mask);

    // CPU read mux; silent unless the chip is selected for a read.
    always_comb begin
        DO = 16'h0000;
        if (!CSn && !RDn) begin
            if (!A2) begin
                DO = status;
            end else begin
                case (rsel)
                    5'h00:   DO = status;
                    5'h05:   DO = {12'b0, cr_q};
                    5'h06:   DO = {6'b0, rcr_q};
                    5'h0F:   DO = {14'b0, dcr_q};
                    default: DO = 16'h0000;
                endcase
            end
        end
    end

    // Register-select latch and control registers written from the CPU bus.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                rsel  <= 5'h00;
                cr_q  <= 4'h0;
                rcr_q <= 10'h000;
                dcr_q <= 2'b00;
            end else if (wr_en) begin
                if (!A2) begin
                    rsel <= DI[4:0];
                end else begin
                    case (rsel)
                        5'h05:   cr_q  <= DI[3:0];
                        5'h06:   rcr_q <= DI[9:0];
                        5'h0F:   dcr_q <= DI[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Event flags with snapshot-based read-clear.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                flags  <= 6'b0;
                snap   <= 6'b0;
                rd_act <= 1'b0;
            end else begin
                flags <= flags_nxt;
                if (rd_start) begin
                    snap   <= flags;
                    rd_act <= 1'b1;
                end else if (rd_end) begin
                    snap   <= 6'b0;
                    rd_act <= 1'b0;
                end
            end
        end
    end
endmodule
